// File: rtl/pattern_gen_pkg.sv
// Shared types, code tables and LFSR taps for the
// switch-pattern stimulus generator.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    localparam logic [1:0] MODE_MAN  = 2'b00;
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_RAND = 2'b10;

    localparam logic [2:0] LO_LAST = 3'd5;
    localparam logic [1:0] HI_LAST = 2'd3;

    // x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [3:0] lo_code(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b0011;
            3'd1:    c = 4'b0101;
            3'd2:    c = 4'b0110;
            3'd3:    c = 4'b1001;
            3'd4:    c = 4'b1010;
            3'd5:    c = 4'b1100;
            default: c = 4'b0011;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] hi_code(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [2:0] fold_lo(input logic [2:0] v);
        return (v >= 3'd6) ? v - 3'd6 : v;
    endfunction

endpackage

// File: rtl/pattern_code_gen_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used for random
// pattern selection.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);
    import pattern_gen_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pattern_code_gen.sv
// Emits 2-of-4 / 1-of-4 code words over valid/ready,
// in manual, auto-enumerate or auto-random order.
module pattern_code_gen #(
    parameter int         TICK_DIV  = 100_000_000,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] mode,
    input  logic       inj,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       code_bad,
    output logic       busy,
    output logic       wrapped
);
    import pattern_gen_pkg::*;

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    state_t        state, state_d;
    logic [2:0]    lo_idx, lo_d, lo_l;
    logic [1:0]    hi_idx, hi_d, hi_l;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    code_d;
    logic [7:0]    lfsr;
    logic          bad_d, wrap_d;
    logic          rnd, rnd_d;
    logic          load;
    logic          rand_mode, auto_mode, tick;
    logic          unused_lfsr;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign unused_lfsr = ^lfsr[7:5];
    assign rand_mode   = (mode == MODE_RAND);
    assign auto_mode   = (mode == MODE_AUTO) || rand_mode;
    assign tick        = (cnt == TICK_MAX);
    assign code_valid  = (state == PRESENT);
    assign busy        = (state != IDLE);

    always_comb begin
        state_d = state;
        lo_d    = lo_idx;
        hi_d    = hi_idx;
        cnt_d   = cnt;
        code_d  = code;
        bad_d   = code_bad;
        rnd_d   = rnd;
        wrap_d  = 1'b0;
        load    = 1'b0;
        lo_l    = lo_idx;
        hi_l    = hi_idx;

        unique case (state)
            IDLE: begin
                load = start;
            end
            PRESENT: begin
                if (code_ready) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    // random words leave the enumeration position alone
                    if (!rnd) begin
                        wrap_d = (lo_idx == LO_LAST) && (hi_idx == HI_LAST);
                        if (lo_idx == LO_LAST) begin
                            lo_d = '0;
                            hi_d = hi_idx + 2'd1;
                        end else begin
                            lo_d = lo_idx + 3'd1;
                        end
                    end
                end
            end
            GAP: begin
                cnt_d = cnt + CW'(1);
                load  = auto_mode ? tick : step;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rand_mode) begin
            lo_l = fold_lo(lfsr[2:0]);
            hi_l = lfsr[4:3];
        end

        if (load && !stop) begin
            state_d = PRESENT;
            lo_d    = lo_l;
            hi_d    = hi_l;
            code_d  = {hi_code(hi_l), lo_code(lo_l)} ^ {7'd0, inj};
            bad_d   = inj;
            rnd_d   = rand_mode;
        end

        if (stop) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lo_idx   <= '0;
            hi_idx   <= '0;
            cnt      <= '0;
            code     <= '0;
            code_bad <= 1'b0;
            wrapped  <= 1'b0;
            rnd      <= 1'b0;
        end else begin
            state    <= state_d;
            lo_idx   <= lo_d;
            hi_idx   <= hi_d;
            cnt      <= cnt_d;
            code     <= code_d;
            code_bad <= bad_d;
            wrapped  <= wrap_d;
            rnd      <= rnd_d;
        end
    end

endmodule

// File: tb/tb_pattern_code_gen.sv
// Directed bench for pattern_code_gen with a per-cycle
// reference model and literal checks on key words.
module tb_pattern_code_gen;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       inj = 1'b0;
    logic       code_ready = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       code_bad;
    logic       busy;
    logic       wrapped;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wrap_cnt = 0;
    bit chk_en = 1'b0;

    pattern_code_gen #(.TICK_DIV(TD), .LFSR_SEED(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .mode       (mode),
        .inj        (inj),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_bad   (code_bad),
        .busy       (busy),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: pair index p = hi*6 + lo
    logic [3:0] lo_tab [6] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
    logic [3:0] hi_tab [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    int         m_st = 0;
    int         m_p = 0;
    int         m_gap = 0;
    logic [7:0] m_lf = 8'hA5;
    logic [7:0] m_code = 8'h00;
    logic       m_bad = 1'b0;
    logic       m_wrap = 1'b0;
    logic       m_rnd = 1'b0;

    function automatic logic [7:0] lf_next(input logic [7:0] v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((int'(v) << 1) | fb) & 255);
    endfunction

    always @(posedge clk) begin
        int cur, l, h, nx;
        bit ld;
        if (rst) begin
            m_st = 0; m_p = 0; m_gap = 0; m_lf = 8'hA5;
            m_code = 8'h00; m_bad = 0; m_wrap = 0; m_rnd = 0;
        end else begin
            cur = int'(m_lf);
            m_lf = lf_next(m_lf);
            m_wrap = 0;
            ld = 0;
            nx = m_st;
            if (m_st == 0) begin
                ld = start;
            end else if (m_st == 1) begin
                if (code_ready) begin
                    nx = 2;
                    m_gap = 0;
                    if (!m_rnd) begin
                        m_wrap = (m_p == 23);
                        m_p = (m_p + 1) % 24;
                    end
                end
            end else begin
                if (mode == 2'b01 || mode == 2'b10) ld = (m_gap == TD - 1);
                else ld = step;
                m_gap++;
            end
            if (ld && !stop) begin
                if (mode == 2'b10) begin
                    l = cur % 8;
                    if (l > 5) l -= 6;
                    h = (cur / 8) % 4;
                    m_p = h * 6 + l;
                end
                l = m_p % 6;
                h = m_p / 6;
                m_code = {hi_tab[h], lo_tab[l]};
                if (inj) m_code[0] = ~m_code[0];
                m_bad = inj;
                m_rnd = (mode == 2'b10);
                nx = 1;
            end
            if (stop) nx = 0;
            m_st = nx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_code", code, m_code);
            chk("m_valid", code_valid, m_st == 1);
            chk("m_busy", busy, m_st != 0);
            chk("m_bad", code_bad, m_bad);
            chk("m_wrapped", wrapped, m_wrap);
            if (wrapped) wrap_cnt++;
        end
    end

    logic [7:0] enum_tab [24] = '{
        8'h13, 8'h15, 8'h16, 8'h19, 8'h1A, 8'h1C,
        8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h43, 8'h45, 8'h46, 8'h49, 8'h4A, 8'h4C,
        8'h83, 8'h85, 8'h86, 8'h89, 8'h8A, 8'h8C
    };

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_valid(output logic [7:0] c);
        int n;
        n = 0;
        while (!code_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!code_valid) chk("valid_timeout", 0, 1);
        c = code;
    endtask

    initial begin
        logic [7:0] c;
        int t [6];

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_code", code, 8'h00);
        chk("rst_valid", code_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bad", code_bad, 0);
        chk("rst_wrapped", wrapped, 0);
        rst = 1'b0;

        // manual enumeration through one full wrap
        mode = 2'b00;
        code_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) pulse_start();
            else pulse_step();
            wait_valid(c);
            chk("man_code", c, enum_tab[i]);
        end
        chk("wrap_early", wrap_cnt, 0);
        @(negedge clk);
        chk("wrap_pulse", wrapped, 1);
        pulse_step();
        wait_valid(c);
        chk("after_wrap", c, 8'h13);
        chk("wrap_once", wrap_cnt, 1);
        @(negedge clk);

        // backpressure holds the word
        code_ready = 1'b0;
        pulse_step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", code_valid, 1);
            chk("bp_code", code, 8'h15);
            @(negedge clk);
        end
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        chk("bp_release", code_valid, 0);
        pulse_stop();
        chk("stop_idle", busy, 0);

        // fault inject from pair (0,0)
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        code_ready = 1'b1;
        inj = 1'b1;
        pulse_start();
        wait_valid(c);
        chk("inj_code", c, 8'h12);
        chk("inj_bad", code_bad, 1);
        @(negedge clk);
        inj = 1'b0;
        pulse_step();
        wait_valid(c);
        chk("post_inj_code", c, 8'h15);
        chk("post_inj_bad", code_bad, 0);
        @(negedge clk);

        // reset while presenting
        code_ready = 1'b0;
        pulse_step();
        chk("pre_rst_code", code, 8'h16);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_code", code, 8'h00);
        chk("mid_rst_valid", code_valid, 0);
        chk("mid_rst_busy", busy, 0);
        code_ready = 1'b1;
        pulse_start();
        wait_valid(c);
        chk("rst_restart", c, 8'h13);
        @(negedge clk);

        // acceptance and stop in the same cycle
        code_ready = 1'b0;
        pulse_step();
        chk("acc_stop_word", code, 8'h15);
        code_ready = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("acc_stop_valid", code_valid, 0);
        chk("acc_stop_busy", busy, 0);
        pulse_start();
        wait_valid(c);
        chk("acc_stop_adv", c, 8'h16);
        @(negedge clk);

        // start and stop together
        pulse_stop();
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("start_stop", busy, 0);

        // auto enumeration, then switch to random
        mode = 2'b01;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            wait_valid(c);
            chk("auto_code", c, enum_tab[3 + i]);
            t[i] = cyc;
            if (i == 5) mode = 2'b10;
            @(negedge clk);
        end
        for (int i = 1; i < 6; i++) begin
            chk("auto_spacing", t[i] - t[i-1], TD + 1);
        end

        for (int i = 0; i < 200; i++) begin
            wait_valid(c);
            chk("rand_lo", c[3:0] inside {4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC}, 1);
            chk("rand_hi", $onehot(c[7:4]), 1);
            chk("rand_bad", code_bad, 0);
            @(negedge clk);
        end
        pulse_stop();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
